// File: rtl/sram_read_slave.sv
// sram_read_slave: AXI4 read-channel slave that serves bursts from a 1-cycle-latency on-chip SRAM
module sram_read_slave #(
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  ARID_S,
  input  logic [ADDR_W-1:0] ARADDR_S,
  input  logic [LEN_W-1:0]  ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [IDS_W-1:0]  RID_S,
  output logic [DATA_W-1:0] RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  output logic              mem_ce,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, CAPT, RESP} state_t;
  state_t state;
  logic [LEN_W-1:0] cnt;
  logic fixed, err;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ARADDR_S[ADDR_W-1:MEM_AW+2], ARADDR_S[1:0]};
  // mem_addr doubles as the burst word pointer; it only matters to the SRAM while mem_ce is high
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ARREADY_S <= 1'b1;
      RVALID_S  <= 1'b0;
      RLAST_S   <= 1'b0;
      RRESP_S   <= 2'b00;
      RID_S     <= '0;
      RDATA_S   <= '0;
      mem_ce    <= 1'b0;
      mem_addr  <= '0;
      cnt       <= '0;
      fixed     <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ARVALID_S && ARREADY_S) begin
          ARREADY_S <= 1'b0;
          RID_S     <= ARID_S;
          mem_addr  <= ARADDR_S[MEM_AW+1:2];
          cnt       <= ARLEN_S;
          fixed     <= ARBURST_S == 2'b00;
          err       <= ARSIZE_S != 3'b010;
          mem_ce    <= ARSIZE_S == 3'b010;
          state     <= FETCH;
        end
        FETCH: begin
          mem_ce <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          RDATA_S  <= err ? '0 : mem_rdata;
          RRESP_S  <= err ? 2'b10 : 2'b00;
          RLAST_S  <= cnt == '0;
          RVALID_S <= 1'b1;
          state    <= RESP;
        end
        RESP: if (RREADY_S) begin
          RVALID_S <= 1'b0;
          RLAST_S  <= 1'b0;
          if (cnt == '0) begin
            ARREADY_S <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt      <= cnt - 1'b1;
            mem_addr <= mem_addr + MEM_AW'(!fixed);
            mem_ce   <= !err;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_read_slave.sv
// tb_sram_read_slave: directed and randomized bursts checked against a per-beat burst model
module tb_sram_read_slave;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [7:0] ARID_S, RID_S;
  logic [31:0] ARADDR_S, RDATA_S, mem_rdata;
  logic [3:0] ARLEN_S;
  logic [2:0] ARSIZE_S;
  logic [1:0] ARBURST_S, RRESP_S;
  logic ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, mem_ce;
  logic [13:0] mem_addr;
  logic [31:0] mem [16384];
  int compared = 0, mismatched = 0;

  sram_read_slave dut (
    .clk(clk), .rst(rst), .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S), .RVALID_S(RVALID_S),
    .RREADY_S(RREADY_S), .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) if (mem_ce) mem_rdata <= mem[mem_addr];

  logic prev_ce = 0;
  int ce_double = 0;
  logic [13:0] ce_q[$];
  always @(negedge clk) begin
    if (mem_ce) ce_q.push_back(mem_addr);
    if (mem_ce && prev_ce) ce_double++;
    prev_ce = mem_ce;
  end

  logic [31:0] bd[$];
  logic [7:0] bi[$];
  logic [1:0] br[$];
  logic bl[$];
  int bt[$];
  int lat, hold_err, busy_err;
  logic arr_after;
  bit tmo;

  function automatic logic [13:0] exp_word(input logic [31:0] addr, input logic [1:0] burst, input int i);
    return 14'((addr >> 2) + (burst == 2'b00 ? 0 : i));
  endfunction

  // Issues one AR (called at a negedge), then collects every R beat; ARVALID carries junk while busy
  task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_n, input int rnd_pct);
    int k, w, st;
    logic [42:0] hd;
    bit held;
    bd.delete(); bi.delete(); br.delete(); bl.delete(); bt.delete(); ce_q.delete();
    lat = -1; hold_err = 0; busy_err = 0; tmo = 0; held = 0; st = 0; hd = '0;
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = size; ARBURST_S = burst;
    ARVALID_S = 1; RREADY_S = 0;
    w = 0;
    while (!ARREADY_S && w < 100) begin @(negedge clk); w++; end
    if (!ARREADY_S) tmo = 1;
    @(negedge clk);
    ARID_S = ~id; ARADDR_S = $urandom; ARSIZE_S = 3'b010; ARBURST_S = 2'b01;
    k = 1;
    while (bd.size() <= int'(len) && k < 400) begin
      if (RVALID_S && lat < 0) lat = k;
      if (ARREADY_S) busy_err++;
      if (RVALID_S && held && {RID_S, RRESP_S, RLAST_S, RDATA_S} !== hd) hold_err++;
      RREADY_S = 1;
      if (RVALID_S && bd.size() == stall_beat && st < stall_n) begin RREADY_S = 0; st++; end
      if (RVALID_S && rnd_pct > 0 && $urandom_range(99) < rnd_pct) RREADY_S = 0;
      held = 0;
      if (RVALID_S && RREADY_S) begin
        bd.push_back(RDATA_S); bi.push_back(RID_S); br.push_back(RRESP_S);
        bl.push_back(RLAST_S); bt.push_back(k);
        if (bd.size() > int'(len)) ARVALID_S = 0;
      end else if (RVALID_S) begin
        held = 1; hd = {RID_S, RRESP_S, RLAST_S, RDATA_S};
      end
      @(negedge clk); k++;
    end
    ARVALID_S = 0; RREADY_S = 0;
    if (bd.size() <= int'(len)) tmo = 1;
    arr_after = ARREADY_S;
  endtask

  task automatic test_reset;
    logic [59:0] got, exp;
    rst = 1;
    repeat (3) @(negedge clk);
    got = {ARREADY_S, RVALID_S, RLAST_S, RRESP_S, RID_S, RDATA_S, mem_ce, mem_addr};
    exp = {1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0, 1'b0, 14'h0};
    compared++;
    if (got !== exp) begin mismatched++; $display("FAIL reset_state got=%h want=%h", got, exp); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    mem[14'h40] = 32'hDEADBEEF;
    do_burst(8'h12, 32'h100, 4'd0, 3'b010, 2'b01, -1, 0, 0);
    compared++;
    if (tmo || bd.size() != 1) begin mismatched++; $display("FAIL single_count got=%0d want=1 tmo=%0b", bd.size(), tmo); end
    else begin
      compared++;
      if ({bi[0], bd[0], bl[0], br[0]} !== {8'h12, 32'hDEADBEEF, 1'b1, 2'b00}) begin
        mismatched++; $display("FAIL single_beat got id=%h data=%h last=%b resp=%b want 12 deadbeef 1 00", bi[0], bd[0], bl[0], br[0]);
      end
    end
    compared++;
    if (lat !== 3) begin mismatched++; $display("FAIL single_latency got=%0d want=3", lat); end
    compared++;
    if (arr_after !== 1'b1 || busy_err !== 0) begin
      mismatched++; $display("FAIL single_arready got after=%b busy=%0d want 1 0", arr_after, busy_err);
    end
    compared++;
    if (ce_q.size() != 1 || ce_q[0] !== 14'h40) begin mismatched++; $display("FAIL single_mem_addr got n=%0d want one read of 0040", ce_q.size()); end
  endtask

  task automatic test_incr_stall;
    for (int i = 0; i < 4; i++) mem[i] = i + 1;
    do_burst(8'h3C, 32'h0, 4'd3, 3'b010, 2'b01, 0, 2, 0);
    compared++;
    if (tmo || bd.size() != 4) begin mismatched++; $display("FAIL incr_count got=%0d want=4", bd.size()); end
    for (int i = 0; i < bd.size() && i < 4; i++) begin
      compared++;
      if ({bi[i], bd[i], bl[i], br[i]} !== {8'h3C, 32'(i + 1), i == 3, 2'b00}) begin
        mismatched++; $display("FAIL incr_beat%0d got data=%h last=%b id=%h want data=%h last=%b", i, bd[i], bl[i], bi[i], i + 1, i == 3);
      end
    end
    compared++;
    if (hold_err !== 0) begin mismatched++; $display("FAIL incr_hold got=%0d changes want=0", hold_err); end
    compared++;
    if (bt.size() != 4 || bt[0] != 5 || bt[3] != 14) begin
      mismatched++; $display("FAIL incr_timing got n=%0d want handshakes at 5,8,11,14", bt.size());
    end
  endtask

  task automatic test_fixed;
    bit ok;
    mem[8] = 32'hA5A5A5A5;
    mem[9] = 32'h5A5A5A5A;
    do_burst(8'h77, 32'h20, 4'd2, 3'b010, 2'b00, -1, 0, 0);
    compared++;
    if (tmo || bd.size() != 3) begin mismatched++; $display("FAIL fixed_count got=%0d want=3", bd.size()); end
    for (int i = 0; i < bd.size() && i < 3; i++) begin
      compared++;
      if ({bd[i], bl[i], bt[i]} !== {32'hA5A5A5A5, i == 2, 3 + 3 * i}) begin
        mismatched++; $display("FAIL fixed_beat%0d got data=%h last=%b cyc=%0d want a5a5a5a5 %b %0d", i, bd[i], bl[i], bt[i], i == 2, 3 + 3 * i);
      end
    end
    ok = ce_q.size() == 3;
    foreach (ce_q[i]) ok &= ce_q[i] == 14'd8;
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL fixed_mem_addr got n=%0d want three reads of 0008", ce_q.size()); end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    a = 32'h5A5AFFFE;
    mem[14'h3FFF] = $urandom;
    mem[0] = $urandom;
    do_burst(8'hE1, a, 4'd1, 3'b010, 2'b01, -1, 0, 0);
    compared++;
    if (ce_q.size() != 2 || ce_q[0] !== 14'h3FFF || ce_q[1] !== 14'h0000) begin
      mismatched++; $display("FAIL wrap_mem_addr got n=%0d want 3fff then 0000", ce_q.size());
    end
    compared++;
    if (tmo || bd.size() != 2 || bd[0] !== mem[14'h3FFF] || bd[1] !== mem[0]) begin
      mismatched++; $display("FAIL wrap_data got n=%0d want %h %h", bd.size(), mem[14'h3FFF], mem[0]);
    end
  endtask

  task automatic test_err;
    do_burst(8'h5E, 32'h400, 4'd1, 3'b001, 2'b01, -1, 0, 0);
    compared++;
    if (tmo || bd.size() != 2) begin mismatched++; $display("FAIL err_count got=%0d want=2", bd.size()); end
    for (int i = 0; i < bd.size() && i < 2; i++) begin
      compared++;
      if ({bi[i], br[i], bd[i], bl[i]} !== {8'h5E, 2'b10, 32'h0, i == 1}) begin
        mismatched++; $display("FAIL err_beat%0d got resp=%b data=%h last=%b want 10 0 %b", i, br[i], bd[i], bl[i], i == 1);
      end
    end
    compared++;
    if (ce_q.size() != 0) begin mismatched++; $display("FAIL err_mem_ce got=%0d reads want=0", ce_q.size()); end
  endtask

  task automatic test_reset_mid;
    int n, w, extra;
    bit seen;
    ARID_S = 8'h99; ARADDR_S = 32'h800; ARLEN_S = 4'd7; ARSIZE_S = 3'b010; ARBURST_S = 2'b01;
    ARVALID_S = 1; RREADY_S = 0;
    w = 0;
    while (!ARREADY_S && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    ARVALID_S = 0; RREADY_S = 1;
    n = 0; seen = 0; w = 0;
    while (!seen && w < 100) begin
      if (RVALID_S && n == 1) seen = 1;
      else begin
        if (RVALID_S) n++;
        @(negedge clk); w++;
      end
    end
    compared++;
    if (!seen) begin mismatched++; $display("FAIL rstmid_beat2 got beats=%0d want second beat valid", n); end
    rst = 1; RREADY_S = 0;
    @(negedge clk);
    compared++;
    if ({RVALID_S, ARREADY_S, mem_ce} !== 3'b010) begin
      mismatched++; $display("FAIL rstmid_state got valid=%b arready=%b ce=%b want 0 1 0", RVALID_S, ARREADY_S, mem_ce);
    end
    rst = 0; RREADY_S = 1; extra = 0;
    repeat (12) begin @(negedge clk); if (RVALID_S || mem_ce) extra++; end
    compared++;
    if (extra !== 0) begin mismatched++; $display("FAIL rstmid_dropped got=%0d active cycles want=0", extra); end
    mem[14'h123] = 32'hC0FFEE00;
    mem[14'h124] = 32'h0BADF00D;
    do_burst(8'h4B, 32'h48C, 4'd1, 3'b010, 2'b01, -1, 0, 0);
    compared++;
    if (tmo || bd.size() != 2 || {bd[0], bd[1], bi[1], bl[1]} !== {32'hC0FFEE00, 32'h0BADF00D, 8'h4B, 1'b1}) begin
      mismatched++; $display("FAIL rstmid_after got n=%0d want c0ffee00 0badf00d id 4b", bd.size());
    end
  endtask

  task automatic test_random;
    logic [7:0] id;
    logic [31:0] addr;
    logic [3:0] len;
    logic [2:0] sz;
    logic [1:0] bu;
    logic [42:0] got, exp;
    bit e, ok;
    for (int t = 0; t < 24; t++) begin
      id = 8'($urandom); addr = $urandom; len = 4'($urandom); bu = 2'($urandom);
      sz = ($urandom_range(4) == 0) ? 3'($urandom_range(7)) : 3'b010;
      e = sz != 3'b010;
      do_burst(id, addr, len, sz, bu, -1, 0, 30);
      compared++;
      if (tmo || bd.size() != int'(len) + 1) begin
        mismatched++; $display("FAIL rand%0d_count got=%0d want=%0d", t, bd.size(), len + 1);
      end
      for (int i = 0; i < bd.size() && i <= int'(len); i++) begin
        exp = {id, e ? 2'b10 : 2'b00, i == int'(len), e ? 32'h0 : mem[exp_word(addr, bu, i)]};
        got = {bi[i], br[i], bl[i], bd[i]};
        compared++;
        if (got !== exp) begin mismatched++; $display("FAIL rand%0d_beat%0d got=%h want=%h", t, i, got, exp); end
      end
      compared++;
      if (hold_err !== 0 || busy_err !== 0 || arr_after !== 1'b1 || lat !== 3) begin
        mismatched++; $display("FAIL rand%0d_status got hold=%0d busy=%0d arready=%b lat=%0d want 0 0 1 3", t, hold_err, busy_err, arr_after, lat);
      end
      ok = ce_q.size() == (e ? 0 : int'(len) + 1);
      foreach (ce_q[i]) ok &= ce_q[i] == exp_word(addr, bu, i);
      compared++;
      if (ok !== 1'b1) begin mismatched++; $display("FAIL rand%0d_mem_addr got n=%0d want %0d matching reads", t, ce_q.size(), e ? 0 : len + 1); end
    end
    compared++;
    if (ce_double !== 0) begin mismatched++; $display("FAIL mem_ce_consecutive got=%0d want=0", ce_double); end
  endtask

  initial begin
    ARID_S = 0; ARADDR_S = 0; ARLEN_S = 0; ARSIZE_S = 3'b010; ARBURST_S = 2'b01;
    ARVALID_S = 0; RREADY_S = 0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    @(negedge clk);
    test_reset;
    test_single;
    test_incr_stall;
    test_fixed;
    test_wrap;
    test_err;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
